// File: rtl/cipher_uart_tx.sv
// Ciphertext byte FIFO feeding an 8N1 UART transmitter (idle-high line).
// Optional CR/LF trailer after each drained burst: define CIPHER_UART_CRLF_EN.
module cipher_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic [7:0]        i_data,
  input  logic              i_valid,
  output logic              o_uart_tx,
  output logic              o_busy,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_overflow
);

`ifdef CIPHER_UART_CRLF_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_CR, S_LF} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            r_state;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wptr, r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ovf;
  logic [15:0]       r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_tx;
`ifdef CIPHER_UART_CRLF_EN
  logic [3:0]        r_tbit;
  logic [8:0]        r_tframe;
`endif

  logic w_full, w_pop, w_push, w_bit_end;

  assign w_full    = (r_count == (ADDR_W+1)'(FIFO_DEPTH));
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  // A pop frees a slot in the same edge, so a push into a full FIFO still lands.
  assign w_push    = i_valid && (!w_full || w_pop);
  assign w_bit_end = (r_baud == 16'(CLKS_PER_BIT - 1));

  assign o_uart_tx  = r_tx;
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_overflow = r_ovf;
  assign o_busy     = (r_state != S_IDLE) || (r_count != '0);

  always_ff @(posedge CLOCK_50) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_valid && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
`ifdef CIPHER_UART_CRLF_EN
      r_tbit   <= '0;
      r_tframe <= '0;
`endif
    end else begin
      r_baud <= r_baud + 16'd1;
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_tx   <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
`ifdef CIPHER_UART_CRLF_EN
            if (r_count == '0) begin
              r_tx     <= 1'b0;
              r_tbit   <= '0;
              r_tframe <= {1'b1, 8'h0D};
              r_state  <= S_CR;
            end
`endif
          end
        end
`ifdef CIPHER_UART_CRLF_EN
        // Trailer frames: r_tframe holds data bits then the stop bit, LSB next.
        S_CR, S_LF: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_tbit == 4'd9) begin
              if (r_state == S_CR) begin
                r_tx     <= 1'b0;
                r_tbit   <= '0;
                r_tframe <= {1'b1, 8'h0A};
                r_state  <= S_LF;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_IDLE;
              end
            end else begin
              r_tbit   <= r_tbit + 4'd1;
              r_tx     <= r_tframe[0];
              r_tframe <= r_tframe >> 1;
            end
          end
        end
`endif
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_uart_tx.sv
// Randomised and directed bench for cipher_uart_tx against a frame-level
// queue model (byte queue + cycles-remaining-in-frame).
module tb_cipher_uart_tx;
  localparam int CPB = 4;
  localparam int DEP = 4;
  localparam int AW  = 2;
  localparam int FL  = 10 * CPB;

  logic          CLOCK_50 = 1'b0;
  logic          reset_n  = 1'b0;
  logic [7:0]    i_data   = '0;
  logic          i_valid  = 1'b0;
  logic          o_uart_tx, o_busy, o_full, o_overflow;
  logic [AW:0]   o_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_q[$];
  int         m_rem  = 0;
  logic [7:0] m_byte = '0;
  int         m_kind = 0;
  bit         m_ovf  = 1'b0;

  cipher_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP), .ADDR_W(AW)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_uart_tx (o_uart_tx),
    .o_busy    (o_busy),
    .o_count   (o_count),
    .o_full    (o_full),
    .o_overflow(o_overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic m_tx();
    logic [9:0] fr;
    if (m_rem == 0) return 1'b1;
    fr = {1'b1, m_byte, 1'b0};
    return fr[(FL - m_rem) / CPB];
  endfunction

  task automatic m_step(input bit v, input logic [7:0] d);
    int sz;
    bit pop;
    sz  = m_q.size();
    pop = (m_rem == 0) && (sz > 0);
    if (pop) begin
      m_byte = m_q.pop_front();
      m_rem  = FL;
      m_kind = 0;
    end else if (m_rem > 0) begin
      m_rem--;
`ifdef CIPHER_UART_CRLF_EN
      if (m_rem == 0) begin
        if (m_kind == 0 && sz == 0) begin
          m_kind = 1; m_byte = 8'h0D; m_rem = FL;
        end else if (m_kind == 1) begin
          m_kind = 2; m_byte = 8'h0A; m_rem = FL;
        end
      end
`endif
    end
    if (v) begin
      if (sz < DEP || pop) m_q.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("tx",    32'(o_uart_tx),  32'(m_tx()));
    chk("count", 32'(o_count),    32'(m_q.size()));
    chk("full",  32'(o_full),     32'(m_q.size() == DEP));
    chk("ovf",   32'(o_overflow), 32'(m_ovf));
    chk("busy",  32'(o_busy),     32'(m_rem != 0 || m_q.size() != 0));
  endtask

  // One clock: drive at negedge, step model at posedge, compare at next negedge.
  task automatic cyc(input bit v, input logic [7:0] d);
    i_valid = v;
    i_data  = d;
    @(posedge CLOCK_50);
    m_step(v, d);
    @(negedge CLOCK_50);
    i_valid = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_tx",    32'(o_uart_tx),  32'd1);
    chk("rst_count", 32'(o_count),    32'd0);
    chk("rst_busy",  32'(o_busy),     32'd0);
    chk("rst_ovf",   32'(o_overflow), 32'd0);
    chk("rst_full",  32'(o_full),     32'd0);
    m_q.delete();
    m_rem = 0; m_kind = 0; m_ovf = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
  endtask

  initial begin
    int guard;
    @(negedge CLOCK_50);
    do_reset();

    // single byte 0x4B: line falls one cycle after the strobe
    cyc(1'b1, 8'h4B);
    chk("sb_still_idle", 32'(o_uart_tx), 32'd1);
    cyc(1'b0, 8'h00);
    chk("sb_fall", 32'(o_uart_tx), 32'd0);
    idle(FL + 4);
    chk("sb_done_busy", 32'(o_busy), 32'd0);

    // burst of three
    cyc(1'b1, 8'h01); cyc(1'b1, 8'h02); cyc(1'b1, 8'h03);
    chk("burst_peak", 32'(o_count), 32'd2);
    idle(3 * (FL + 1) + 100);

    // overflow: six consecutive strobes
    for (int k = 0; k < 6; k++) cyc(1'b1, 8'hA0 + 8'(k));
    chk("ovf_full", 32'(o_full),     32'd1);
    chk("ovf_flag", 32'(o_overflow), 32'd1);
    idle(5 * (FL + 1) + 100);
    chk("ovf_sticky", 32'(o_overflow), 32'd1);

    // push and pop in the same cycle while full
    @(negedge CLOCK_50);
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'hC0 + 8'(k));
    guard = 0;
    while (!(m_rem == 0 && m_q.size() > 0) && guard < 200) begin
      cyc(1'b0, 8'h00);
      guard++;
    end
    chk("pp_wait_bound", 32'(guard < 200), 32'd1);
    chk("pp_pre_full", 32'(o_full), 32'd1);
    cyc(1'b1, 8'hEE);
    chk("pp_count", 32'(o_count),    32'd4);
    chk("pp_ovf",   32'(o_overflow), 32'd0);
    idle(5 * (FL + 1) + 100);

    // reset during data bit 3 (frame position 4)
    cyc(1'b1, 8'h96);
    guard = 0;
    while (!(m_rem > 0 && (FL - m_rem) / CPB == 4) && guard < 200) begin
      cyc(1'b0, 8'h00);
      guard++;
    end
    chk("mr_wait_bound", 32'(guard < 200), 32'd1);
    do_reset();
    idle(FL + 20);

    // byte then a second byte around the end of its frame (trailer window)
    cyc(1'b1, 8'h55);
    idle(FL + 5);
    cyc(1'b1, 8'h33);
    idle(6 * (FL + 1) + 50);

    // randomised traffic with occasional bursts and resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 99) < (k % 400 < 60 ? 70 : 8)) begin
        cyc(1'b1, 8'($urandom));
      end else begin
        cyc(1'b0, 8'h00);
      end
    end
    idle(DEP * 3 * (FL + 1) + 100);
    chk("final_idle_busy", 32'(o_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
